// File: rtl/clever_ram.sv
// Single-port 32-bit word RAM with level-held requests and a fixed completion latency.
// A transaction starts whenever the sampled request differs from the latched one.
`timescale 1ns/1ps
module clever_ram #(
    parameter int unsigned SIZE_RAM  = 4096,
    parameter int unsigned ADDR_BITS = 12,
    parameter int unsigned LATENCY   = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] address,
    input  logic [31:0] data,
    input  logic        mode,
    output logic [31:0] out,
    output logic        response
);

    localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    logic [ADDR_BITS-1:0] r_req_addr;
    logic [31:0]          r_req_data;
    logic                 r_req_mode;
    logic [CNT_W-1:0]     r_cnt;
    logic [31:0]          r_out;
    logic                 r_response;

    // Words are stored XOR'd with their index, so an all-zero array reads back as word i = i.
    logic [31:0]          r_mem [SIZE_RAM];

    logic [ADDR_BITS-1:0] w_addr;
    logic                 w_new;
    logic                 w_done;
    logic                 w_mem_we;
    logic [31:0]          w_rd_word;
    logic                 w_unused_addr;

    assign w_addr        = address[ADDR_BITS-1:0];
    assign w_unused_addr = ^address[31:ADDR_BITS];

    assign w_new = (w_addr != r_req_addr) || (data != r_req_data) || (mode != r_req_mode);

    assign w_done    = !w_new && r_response && (r_cnt == '0);
    assign w_mem_we  = rst_n && w_done && r_req_mode;
    assign w_rd_word = r_mem[r_req_addr] ^ 32'(r_req_addr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_req_addr <= '0;
            r_req_data <= '0;
            r_req_mode <= 1'b0;
            r_cnt      <= '0;
            r_out      <= '0;
            r_response <= 1'b0;
        end else if (w_new) begin
            // A new request aborts any in-flight one; nothing is committed until completion.
            r_req_addr <= w_addr;
            r_req_data <= data;
            r_req_mode <= mode;
            r_cnt      <= CNT_W'(LATENCY - 1);
            r_response <= 1'b1;
        end else if (r_response && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end else if (w_done) begin
            r_out      <= r_req_mode ? r_req_data : w_rd_word;
            r_response <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[r_req_addr] <= r_req_data ^ 32'(r_req_addr);
        end
    end

    assign out      = r_out;
    assign response = r_response;

endmodule

// File: tb/tb_clever_ram.sv
// Directed self-checking bench for clever_ram: latency, write/read, wrap, abort and async reset.
`timescale 1ns/1ps
module tb_clever_ram;

    logic        clk;
    logic        rst_n;
    logic [31:0] address;
    logic [31:0] data;
    logic        mode;
    logic [31:0] out;
    logic        response;

    int unsigned n_checks;
    int unsigned n_fails;

    clever_ram #(
        .SIZE_RAM  (4096),
        .ADDR_BITS (12),
        .LATENCY   (4)
    ) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .address  (address),
        .data     (data),
        .mode     (mode),
        .out      (out),
        .response (response)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Counts busy cycles seen on falling edges until response drops (bounded).
    task automatic count_busy(output int unsigned busy);
        busy = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (response) busy++;
            else break;
        end
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic m);
        address = a;
        data    = d;
        mode    = m;
    endtask

    task automatic do_req(input string tag, input logic [31:0] a, input logic [31:0] d,
                          input logic m, input logic [31:0] exp_out);
        int unsigned busy;
        drive(a, d, m);
        count_busy(busy);
        check_eq({tag, "_busy"}, busy, 32'd4);
        check_eq({tag, "_out"}, out, exp_out);
    endtask

    initial begin
        int unsigned busy;
        int unsigned seen;
        n_checks = 0;
        n_fails  = 0;
        rst_n    = 1'b0;
        drive(32'd0, 32'd0, 1'b0);

        repeat (3) @(negedge clk);
        check_eq("rst_response", {31'd0, response}, 32'd0);
        check_eq("rst_out", out, 32'd0);
        rst_n = 1'b1;

        // Idle after reset: inputs equal the reset request, so nothing starts.
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (response) seen++;
        end
        check_eq("idle_busy", seen, 32'd0);
        check_eq("idle_out", out, 32'd0);

        do_req("rd7", 32'd7, 32'd0, 1'b0, 32'd7);
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (response) seen++;
        end
        check_eq("rd7_hold_busy", seen, 32'd0);
        check_eq("rd7_hold_out", out, 32'd7);

        do_req("wr20", 32'd20, 32'hDEADBEEF, 1'b1, 32'hDEADBEEF);
        do_req("rd20", 32'd20, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF);
        do_req("rd21", 32'd21, 32'hDEADBEEF, 1'b0, 32'd21);

        do_req("wrap", 32'd4099, 32'hDEADBEEF, 1'b0, 32'd3);
        drive(32'd3, 32'hDEADBEEF, 1'b0);
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (response) seen++;
        end
        check_eq("wrap_same_busy", seen, 32'd0);

        // Abort a write two cycles in by switching to a read.
        drive(32'd30, 32'h55, 1'b1);
        repeat (2) @(negedge clk);
        check_eq("abort_started", {31'd0, response}, 32'd1);
        do_req("abort_rd31", 32'd31, 32'h55, 1'b0, 32'd31);
        do_req("rd30", 32'd30, 32'h55, 1'b0, 32'd30);

        // Asynchronous reset in the middle of a transaction.
        drive(32'd40, 32'h77, 1'b0);
        repeat (2) @(negedge clk);
        check_eq("mid_busy", {31'd0, response}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("async_rst_response", {31'd0, response}, 32'd0);
        check_eq("async_rst_out", out, 32'd0);
        #1 rst_n = 1'b1;
        count_busy(busy);
        check_eq("post_rst_busy", busy, 32'd4);
        check_eq("post_rst_out", out, 32'd40);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
